// File: rtl/p_bus_rx.sv
// P-bus receiver: demultiplexes sprite/fix/L0 addresses and sprite attributes
// from the 24-bit P bus using a phase counter restarted by each PCK1 fall.
//
// Ports:
//   CLK_24M, nRESET      clock, async active-low reset
//   PCK1, PCK2           sprite / fix address strobes (captured on falls)
//   S2H1, CA4            live address bits passed straight to S_ADDR/C_ADDR
//   nVCS, L0_ROM_DATA    L0 ROM select and data returned onto PBUS[23:16]
//   PBUS                 multiplexed bus; only [23:16] is ever driven here
//   C_ADDR, S_ADDR       latched sprite / fix ROM addresses
//   L0_ADDR              latched L0 ROM address
//   SPR_PAL, SPR_XPOS    latched sprite palette and X position
//   FIX_PAL              latched fix palette
//   LOCKED               phase sequencer synchronised to PCK1
//   C_STB, S_STB         one-clock pulses after each capture
module p_bus_rx (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic        PCK1,
    input  logic        PCK2,
    input  logic        S2H1,
    input  logic        CA4,
    input  logic        nVCS,
    input  logic [7:0]  L0_ROM_DATA,
    inout  wire  [23:0] PBUS,
    output logic [24:0] C_ADDR,
    output logic [16:0] S_ADDR,
    output logic [15:0] L0_ADDR,
    output logic [7:0]  SPR_PAL,
    output logic [7:0]  SPR_XPOS,
    output logic [3:0]  FIX_PAL,
    output logic        LOCKED,
    output logic        C_STB,
    output logic        S_STB
);

    typedef enum logic {UNSYNC, SYNC} lock_t;

    localparam logic [5:0] PH_MAX = 6'd40;

    lock_t       st, st_nxt;
    logic        pck1_q, pck2_q;
    logic        p1_fall, p2_fall;
    logic [5:0]  ph;
    logic [1:0]  nfall;
    logic        in_win;
    logic        slot_ok;
    logic        bus_drv;
    // Captured addresses without their live bits (C_ADDR[4], S_ADDR[3])
    logic [23:0] c_q;
    logic [15:0] s_q;

    assign p1_fall = pck1_q & ~PCK1;
    assign p2_fall = pck2_q & ~PCK2;
    assign in_win  = (ph >= 6'd30) && (ph <= 6'd34);
    assign LOCKED  = (st == SYNC);
    // A PCK1 fall restarts the frame, so it pre-empts any slot capture
    assign slot_ok = LOCKED & ~p1_fall;

    // Live bits are forced low in reset so every address output reads 0
    assign C_ADDR = {c_q[23:4], CA4 & nRESET, c_q[3:0]};
    assign S_ADDR = {s_q[15:4], s_q[3], S2H1 & nRESET, s_q[2:0]};

    assign bus_drv = ~nVCS & LOCKED & (ph >= 6'd3) & (ph <= 6'd10);
    assign PBUS[23:16] = bus_drv ? L0_ROM_DATA : 8'hzz;

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            st <= UNSYNC;
        end else begin
            st <= st_nxt;
        end
    end

    // Lock when a fall lands in the expected window; the second fall
    // after reset is trusted outright so the first frame can lock.
    always_comb begin
        st_nxt = st;
        unique case (st)
            UNSYNC: begin
                if (p1_fall && (in_win || nfall == 2'd1))
                    st_nxt = SYNC;
            end
            SYNC: begin
                if (p1_fall) begin
                    if (!in_win)
                        st_nxt = UNSYNC;
                end else if (ph >= PH_MAX - 6'd1) begin
                    st_nxt = UNSYNC;
                end
            end
        endcase
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            pck1_q   <= 1'b0;
            pck2_q   <= 1'b0;
            ph       <= PH_MAX;
            nfall    <= 2'd0;
            c_q      <= '0;
            s_q      <= '0;
            L0_ADDR  <= '0;
            SPR_PAL  <= '0;
            SPR_XPOS <= '0;
            FIX_PAL  <= '0;
            C_STB    <= 1'b0;
            S_STB    <= 1'b0;
        end else begin
            pck1_q <= PCK1;
            pck2_q <= PCK2;
            C_STB  <= p1_fall;
            S_STB  <= p2_fall;
            if (p1_fall) begin
                c_q <= {PBUS[23:20], PBUS[15:0], PBUS[19:16]};
                ph  <= 6'd0;
                if (nfall != 2'd2)
                    nfall <= nfall + 2'd1;
            end else if (ph != PH_MAX) begin
                ph <= ph + 6'd1;
            end
            if (p2_fall)
                s_q <= {PBUS[11:0], PBUS[15], PBUS[14:12]};
            if (slot_ok && ph == 6'd2)
                L0_ADDR <= PBUS[15:0];
            if (slot_ok && ph == 6'd12) begin
                SPR_PAL  <= PBUS[23:16];
                SPR_XPOS <= PBUS[15:8];
            end
            if (slot_ok && ph == 6'd29)
                FIX_PAL <= PBUS[19:16];
        end
    end

endmodule
